// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between fifo_stream_reader, its paired sync_fifo read port and the downstream stream sink.
// master = the reader, slave = the environment (FIFO read side plus stream consumer).
interface fifo_stream_reader_if #(
    parameter int WIDTH = 64
);
    logic             fifo_rd_en;
    logic [WIDTH-1:0] fifo_rd_data;
    logic             fifo_empty;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       buf_count;

    modport master (
        output fifo_rd_en,
        input  fifo_rd_data,
        input  fifo_empty,
        output out_valid,
        input  out_ready,
        output out_data,
        output buf_count
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_rd_data,
        output fifo_empty,
        input  out_valid,
        output out_ready,
        input  out_data,
        input  buf_count
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drain engine for a registered-read sync_fifo: issues rd_en, lands returning words in a 2-entry skid buffer
// and presents them as a valid/ready stream. Define FIFO_STREAM_RD_STATS_EN to add beat/stall counters.
module fifo_stream_reader #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
`ifdef FIFO_STREAM_RD_STATS_EN
    output logic [CNT_W-1:0]     stat_beats,
    output logic [CNT_W-1:0]     stat_stalls,
`endif
    fifo_stream_reader_if.master bus
);

    logic [WIDTH-1:0] buf_q [2];
    logic [WIDTH-1:0] buf_d [2];
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             head_q, head_d;

    logic             bypass;
    logic             out_valid;
    logic             pop;
    logic             pop_buf;
    logic             enq;
    logic             tail;
    logic             rd_en;
    logic [2:0]       occ_after;

    // A word arriving into an empty buffer is presented straight from the FIFO read register.
    always_comb begin
        bypass    = (count_q == 2'd0) & inflight_q;
        out_valid = (count_q != 2'd0) | inflight_q;
        pop       = out_valid & bus.out_ready;
        pop_buf   = pop & (count_q != 2'd0);
        enq       = inflight_q & ~(pop & bypass);
        tail      = head_q ^ count_q[0];
        occ_after = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        rd_en     = rst_n & ~clr & ~bus.fifo_empty & (occ_after < 3'd2);
    end

    always_comb begin
        buf_d[0]   = buf_q[0];
        buf_d[1]   = buf_q[1];
        count_d    = count_q;
        inflight_d = inflight_q;
        head_d     = head_q;
        if (clr) begin
            count_d    = 2'd0;
            inflight_d = 1'b0;
            head_d     = 1'b0;
        end else begin
            inflight_d = rd_en;
            if (enq) begin
                buf_d[tail] = bus.fifo_rd_data;
            end
            head_d  = head_q ^ pop_buf;
            count_d = count_q + {1'b0, enq} - {1'b0, pop_buf};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q[0]   <= '0;
            buf_q[1]   <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 1'b0;
        end else begin
            buf_q[0]   <= buf_d[0];
            buf_q[1]   <= buf_d[1];
            count_q    <= count_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.out_valid  = out_valid;
    assign bus.out_data   = bypass ? bus.fifo_rd_data : buf_q[head_q];
    assign bus.buf_count  = count_q;

`ifdef FIFO_STREAM_RD_STATS_EN
    logic [CNT_W-1:0] beats_q, beats_d;
    logic [CNT_W-1:0] stalls_q, stalls_d;

    // Counters survive clr on purpose; only rst_n zeroes them.
    always_comb begin
        beats_d  = beats_q + {{(CNT_W-1){1'b0}}, pop};
        stalls_d = stalls_q + {{(CNT_W-1){1'b0}}, out_valid & ~bus.out_ready};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            stalls_q <= '0;
        end else begin
            beats_q  <= beats_d;
            stalls_q <= stalls_d;
        end
    end

    assign stat_beats  = beats_q;
    assign stat_stalls = stalls_q;
`else
    if (CNT_W < 1) begin : g_no_stats
    end
`endif

endmodule
